spu_result_arbiter: RTL and testbench

Collects per-stream packet results from the NOU SPU result encoders, one per stream slot, and serializes them onto a single response channel toward the NOU response queue. Each source gets a one-entry capture slot, and a round-robin arbiter fills a registered output stage with a valid/ready handshake. Per-source overflow is flagged, and saturating OK/ERR result counters are kept for status readout.

---
 rtl/spu_result_arbiter_if.sv | 54 +++++
 rtl/spu_result_arbiter.sv | 176 +++++++++++++++++
 tb/tb_spu_result_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spu_result_arbiter_if.sv
// Source-result bus and serialized response channel of the SPU result arbiter.
// master = arbiter side (consumes sources, drives responses); slave = the environment.
`ifndef NOU_SID_WIDTH
`define NOU_SID_WIDTH 6
`endif
`ifndef NOU_PKT_ID_WIDTH
`define NOU_PKT_ID_WIDTH 10
`endif
`ifndef NOU_ERR_CODE_WIDTH
`define NOU_ERR_CODE_WIDTH 4
`endif
`ifndef NOU_RSP_TYPE_ID_WIDTH
`define NOU_RSP_TYPE_ID_WIDTH 4
`endif
`ifndef SNT_PKT_RSP_TYPE
`define SNT_PKT_RSP_TYPE 4'h3
`endif
`ifndef RSP_STATUS_OK
`define RSP_STATUS_OK 1'b0
`endif
`ifndef RSP_STATUS_ERR
`define RSP_STATUS_ERR 1'b1
`endif

interface spu_result_arbiter_if #(
  parameter int NUM_SRC = 4
);
  localparam int IDX_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]                          src_vld;
  logic [NUM_SRC*`NOU_SID_WIDTH-1:0]           src_sid;
  logic [NUM_SRC*`NOU_PKT_ID_WIDTH-1:0]        src_pkt_id;
  logic [NUM_SRC-1:0]                          src_status;
  logic [NUM_SRC*`NOU_ERR_CODE_WIDTH-1:0]      src_err_code;

  logic                                        rsp_vld;
  logic                                        rsp_rdy;
  logic [`NOU_SID_WIDTH-1:0]                   rsp_sid;
  logic [`NOU_PKT_ID_WIDTH-1:0]                rsp_pkt_id;
  logic                                        rsp_status;
  logic [`NOU_ERR_CODE_WIDTH-1:0]              rsp_err_code;
  logic [`NOU_RSP_TYPE_ID_WIDTH-1:0]           rsp_type;
  logic [IDX_W-1:0]                            rsp_src_idx;

  modport master (
    input  src_vld, src_sid, src_pkt_id, src_status, src_err_code, rsp_rdy,
    output rsp_vld, rsp_sid, rsp_pkt_id, rsp_status, rsp_err_code, rsp_type, rsp_src_idx
  );

  modport slave (
    output src_vld, src_sid, src_pkt_id, src_status, src_err_code, rsp_rdy,
    input  rsp_vld, rsp_sid, rsp_pkt_id, rsp_status, rsp_err_code, rsp_type, rsp_src_idx
  );
endinterface

// File: rtl/spu_result_arbiter.sv
// Per-source one-entry capture slots, round-robin grant into a registered
// valid/ready response stage, sticky overflow flags and saturating OK/ERR counters.
`ifndef NOU_SID_WIDTH
`define NOU_SID_WIDTH 6
`endif
`ifndef NOU_PKT_ID_WIDTH
`define NOU_PKT_ID_WIDTH 10
`endif
`ifndef NOU_ERR_CODE_WIDTH
`define NOU_ERR_CODE_WIDTH 4
`endif
`ifndef NOU_RSP_TYPE_ID_WIDTH
`define NOU_RSP_TYPE_ID_WIDTH 4
`endif
`ifndef SNT_PKT_RSP_TYPE
`define SNT_PKT_RSP_TYPE 4'h3
`endif
`ifndef RSP_STATUS_OK
`define RSP_STATUS_OK 1'b0
`endif
`ifndef RSP_STATUS_ERR
`define RSP_STATUS_ERR 1'b1
`endif

module spu_result_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spu_result_arbiter_if.master bus,
  input  logic                 stat_clr,
  output logic [CNT_WIDTH-1:0] ok_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [NUM_SRC-1:0]   ovf_flag
);
  localparam int SID_W = `NOU_SID_WIDTH;
  localparam int PKT_W = `NOU_PKT_ID_WIDTH;
  localparam int ERR_W = `NOU_ERR_CODE_WIDTH;
  localparam int IDX_W = $clog2(NUM_SRC);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Stage p0: capture slots
  logic [NUM_SRC-1:0] vld_p0;
  logic [SID_W-1:0]   sid_p0 [NUM_SRC];
  logic [PKT_W-1:0]   pkt_p0 [NUM_SRC];
  logic               st_p0  [NUM_SRC];
  logic [ERR_W-1:0]   err_p0 [NUM_SRC];
  logic [IDX_W-1:0]   rr_ptr;

  // Stage p1: registered response
  logic               vld_p1;
  logic [SID_W-1:0]   sid_p1;
  logic [PKT_W-1:0]   pkt_p1;
  logic               st_p1;
  logic [ERR_W-1:0]   err_p1;
  logic [IDX_W-1:0]   idx_p1;

  logic               load;
  logic               hs;
  logic               gnt_found;
  logic               gnt_vld;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic [NUM_SRC-1:0] gnt_oh;
  logic [NUM_SRC-1:0] cap;
  logic [NUM_SRC-1:0] ovf_set;
  int                 cand;

  assign load = ~vld_p1 | bus.rsp_rdy;
  assign hs   = vld_p1 & bus.rsp_rdy;

  // First occupied slot at or after rr_ptr, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      cand_idx = IDX_W'(cand);
      if (!gnt_found && vld_p0[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  assign gnt_vld = load & gnt_found;

  // A slot being granted this cycle can accept a new result without loss.
  always_comb begin
    gnt_oh  = '0;
    cap     = '0;
    ovf_set = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      gnt_oh[i]  = gnt_vld && (gnt_idx == IDX_W'(i));
      cap[i]     = bus.src_vld[i] & (~vld_p0[i] | gnt_oh[i]);
      ovf_set[i] = bus.src_vld[i] & vld_p0[i] & ~gnt_oh[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= '0;
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (cap[i])         vld_p0[i] <= 1'b1;
        else if (gnt_oh[i]) vld_p0[i] <= 1'b0;
      end
      if (gnt_vld)
        rr_ptr <= (gnt_idx == IDX_W'(NUM_SRC - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cap[i]) begin
        sid_p0[i] <= bus.src_sid[i*SID_W +: SID_W];
        pkt_p0[i] <= bus.src_pkt_id[i*PKT_W +: PKT_W];
        st_p0[i]  <= bus.src_status[i];
        err_p0[i] <= (bus.src_status[i] == `RSP_STATUS_OK) ? '0
                                                             : bus.src_err_code[i*ERR_W +: ERR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      sid_p1 <= '0;
      pkt_p1 <= '0;
      st_p1  <= 1'b0;
      err_p1 <= '0;
      idx_p1 <= '0;
    end else if (gnt_vld) begin
      vld_p1 <= 1'b1;
      sid_p1 <= sid_p0[gnt_idx];
      pkt_p1 <= pkt_p0[gnt_idx];
      st_p1  <= st_p0[gnt_idx];
      err_p1 <= err_p0[gnt_idx];
      idx_p1 <= gnt_idx;
    end else if (bus.rsp_rdy) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt   <= '0;
      err_cnt  <= '0;
      ovf_flag <= '0;
    end else if (stat_clr) begin
      ok_cnt   <= '0;
      err_cnt  <= '0;
      ovf_flag <= '0;
    end else begin
      if (hs && st_p1 == `RSP_STATUS_ERR) err_cnt <= sat_inc(err_cnt);
      if (hs && st_p1 == `RSP_STATUS_OK)  ok_cnt  <= sat_inc(ok_cnt);
      ovf_flag <= ovf_flag | ovf_set;
    end
  end

  assign bus.rsp_vld      = vld_p1;
  assign bus.rsp_sid      = sid_p1;
  assign bus.rsp_pkt_id   = pkt_p1;
  assign bus.rsp_status   = st_p1;
  assign bus.rsp_err_code = err_p1;
  assign bus.rsp_src_idx  = idx_p1;
  assign bus.rsp_type     = `SNT_PKT_RSP_TYPE;
endmodule

// File: tb/tb_spu_result_arbiter.sv
// Directed scenarios plus randomized traffic for spu_result_arbiter, checked
// cycle by cycle against a behavioural model of the arbitration rules.
`ifndef NOU_SID_WIDTH
`define NOU_SID_WIDTH 6
`endif
`ifndef NOU_PKT_ID_WIDTH
`define NOU_PKT_ID_WIDTH 10
`endif
`ifndef NOU_ERR_CODE_WIDTH
`define NOU_ERR_CODE_WIDTH 4
`endif
`ifndef NOU_RSP_TYPE_ID_WIDTH
`define NOU_RSP_TYPE_ID_WIDTH 4
`endif
`ifndef SNT_PKT_RSP_TYPE
`define SNT_PKT_RSP_TYPE 4'h3
`endif
`ifndef RSP_STATUS_OK
`define RSP_STATUS_OK 1'b0
`endif
`ifndef RSP_STATUS_ERR
`define RSP_STATUS_ERR 1'b1
`endif

module tb_spu_result_arbiter;
  localparam int N   = 4;
  localparam int CW  = 4;
  localparam int SW  = `NOU_SID_WIDTH;
  localparam int PW  = `NOU_PKT_ID_WIDTH;
  localparam int EW  = `NOU_ERR_CODE_WIDTH;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stat_clr;
  logic [CW-1:0] ok_cnt;
  logic [CW-1:0] err_cnt;
  logic [N-1:0]  ovf_flag;

  spu_result_arbiter_if #(.NUM_SRC(N)) bus ();

  spu_result_arbiter #(.NUM_SRC(N), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .stat_clr (stat_clr),
    .ok_cnt   (ok_cnt),
    .err_cnt  (err_cnt),
    .ovf_flag (ovf_flag)
  );

  always #5 clk = ~clk;

  // Stimulus, one entry per source
  logic [N-1:0]  s_vld;
  logic [N-1:0]  s_st;
  logic [SW-1:0] s_sid [N];
  logic [PW-1:0] s_pkt [N];
  logic [EW-1:0] s_err [N];
  logic          rdy;

  always_comb begin
    bus.src_vld      = s_vld;
    bus.src_status   = s_st;
    bus.rsp_rdy      = rdy;
    bus.src_sid      = '0;
    bus.src_pkt_id   = '0;
    bus.src_err_code = '0;
    for (int i = 0; i < N; i++) begin
      bus.src_sid[i*SW +: SW]      = s_sid[i];
      bus.src_pkt_id[i*PW +: PW]   = s_pkt[i];
      bus.src_err_code[i*EW +: EW] = s_err[i];
    end
  end

  typedef struct packed {
    logic [SW-1:0] sid;
    logic [PW-1:0] pkt;
    logic          st;
    logic [EW-1:0] err;
  } ent_t;

  // Reference model state
  bit           m_has [N];
  ent_t         m_slot [N];
  bit           m_vld;
  ent_t         m_rsp;
  int           m_idx;
  int           m_rr;
  int           m_ok;
  int           m_err;
  logic [N-1:0] m_ovf;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_has[i]  = 0;
      m_slot[i] = '0;
    end
    m_vld = 0; m_rsp = '0; m_idx = 0; m_rr = 0; m_ok = 0; m_err = 0; m_ovf = '0;
  endtask

  // One clock of the arbitration rules, using the inputs currently applied.
  task automatic model_step();
    int g;
    bit hs;
    g  = -1;
    hs = m_vld && rdy;
    if (!m_vld || rdy)
      for (int k = 0; k < N; k++)
        if (g < 0 && m_has[(m_rr + k) % N]) g = (m_rr + k) % N;
    if (stat_clr) begin
      m_ok = 0; m_err = 0; m_ovf = '0;
    end else begin
      if (hs && m_rsp.st == `RSP_STATUS_ERR) m_err = (m_err < CMAX) ? m_err + 1 : CMAX;
      if (hs && m_rsp.st == `RSP_STATUS_OK)  m_ok  = (m_ok  < CMAX) ? m_ok  + 1 : CMAX;
      for (int i = 0; i < N; i++)
        if (s_vld[i] && m_has[i] && g != i) m_ovf[i] = 1'b1;
    end
    if (g >= 0) begin
      m_vld = 1; m_rsp = m_slot[g]; m_idx = g; m_rr = (g + 1) % N;
    end else if (rdy) begin
      m_vld = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (s_vld[i] && (!m_has[i] || g == i)) begin
        m_has[i]  = 1;
        m_slot[i] = '{sid: s_sid[i], pkt: s_pkt[i], st: s_st[i],
                      err: (s_st[i] == `RSP_STATUS_OK) ? '0 : s_err[i]};
      end else if (g == i) begin
        m_has[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("rsp_vld", bus.rsp_vld, m_vld);
    if (m_vld) begin
      chk("rsp_sid", bus.rsp_sid, m_rsp.sid);
      chk("rsp_pkt_id", bus.rsp_pkt_id, m_rsp.pkt);
      chk("rsp_status", bus.rsp_status, m_rsp.st);
      chk("rsp_err_code", bus.rsp_err_code, m_rsp.err);
      chk("rsp_src_idx", bus.rsp_src_idx, m_idx);
    end
    chk("rsp_type", bus.rsp_type, `SNT_PKT_RSP_TYPE);
    chk("ok_cnt", ok_cnt, m_ok);
    chk("err_cnt", err_cnt, m_err);
    chk("ovf_flag", ovf_flag, m_ovf);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    s_vld = '0;
    stat_clr = 1'b0;
  endtask

  task automatic pulse(input int i, input int sid, input int pkt, input logic st, input int err);
    s_vld[i] = 1'b1;
    s_sid[i] = SW'(sid);
    s_pkt[i] = PW'(pkt);
    s_st[i]  = st;
    s_err[i] = EW'(err);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("reset_rsp_vld", bus.rsp_vld, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_ok_cnt", ok_cnt, 0);
    chk("reset_err_cnt", err_cnt, 0);
    chk("reset_ovf", ovf_flag, 0);
    chk("reset_type", bus.rsp_type, `SNT_PKT_RSP_TYPE);
  endtask

  initial begin
    rst_n = 1'b0;
    rdy   = 1'b0;
    idle_inputs();
    s_st  = '0;
    for (int i = 0; i < N; i++) begin
      s_sid[i] = '0; s_pkt[i] = '0; s_err[i] = '0;
    end

    // Single result: two-cycle latency, OK masks the error code
    do_reset();
    rdy = 1'b1;
    pulse(2, 5, 3, `RSP_STATUS_OK, 9);
    step();
    idle_inputs();
    chk("single_early", bus.rsp_vld, 0);
    step();
    chk("single_vld", bus.rsp_vld, 1);
    chk("single_sid", bus.rsp_sid, 5);
    chk("single_pkt", bus.rsp_pkt_id, 3);
    chk("single_err", bus.rsp_err_code, 0);
    chk("single_idx", bus.rsp_src_idx, 2);
    step();
    chk("single_once", bus.rsp_vld, 0);
    chk("single_ok_cnt", ok_cnt, 1);

    // Round-robin over two simultaneous bursts
    do_reset();
    rdy = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < N; i++) pulse(i, 10 + i, 100 * b + i, `RSP_STATUS_OK, 0);
      step();
      idle_inputs();
      for (int k = 0; k < N; k++) begin
        step();
        chk("rr_idx", bus.rsp_src_idx, k);
      end
      step();
    end

    // Backpressure: held response stays stable
    do_reset();
    rdy = 1'b0;
    pulse(1, 11, 21, `RSP_STATUS_ERR, 4);
    pulse(3, 13, 23, `RSP_STATUS_OK, 7);
    step();
    idle_inputs();
    step();
    for (int c = 0; c < 10; c++) begin
      step();
      chk("bp_hold_vld", bus.rsp_vld, 1);
      chk("bp_hold_sid", bus.rsp_sid, 11);
      chk("bp_hold_pkt", bus.rsp_pkt_id, 21);
    end
    rdy = 1'b1;
    step();
    chk("bp_second_idx", bus.rsp_src_idx, 3);
    chk("bp_second_err", bus.rsp_err_code, 0);
    step();
    chk("bp_drained", bus.rsp_vld, 0);
    chk("bp_no_ovf", ovf_flag, 0);

    // Overflow: second pulse dropped while slot 0 and the output are full
    do_reset();
    rdy = 1'b0;
    pulse(1, 1, 50, `RSP_STATUS_OK, 0);
    step();
    idle_inputs();
    pulse(0, 2, 1, `RSP_STATUS_OK, 0);
    step();
    idle_inputs();
    pulse(0, 2, 2, `RSP_STATUS_OK, 0);
    step();
    idle_inputs();
    chk("ovf_set", ovf_flag, 4'b0001);
    rdy = 1'b1;
    step();
    chk("ovf_deliver_idx", bus.rsp_src_idx, 0);
    chk("ovf_deliver_pkt", bus.rsp_pkt_id, 1);
    step();
    chk("ovf_nothing_more", bus.rsp_vld, 0);
    step();

    // Saturation of err_cnt and clear racing a handshake
    do_reset();
    rdy = 1'b1;
    for (int n = 0; n < 17; n++) begin
      pulse(n % N, n, n, `RSP_STATUS_ERR, n);
      step();
      idle_inputs();
    end
    repeat (3) step();
    chk("sat_err_cnt", err_cnt, CMAX);
    rdy = 1'b0;
    pulse(1, 3, 3, `RSP_STATUS_ERR, 1);
    step();
    idle_inputs();
    pulse(1, 3, 4, `RSP_STATUS_ERR, 1);
    step();
    idle_inputs();
    pulse(1, 3, 5, `RSP_STATUS_ERR, 1);
    step();
    idle_inputs();
    chk("sat_ovf_pre", ovf_flag, 4'b0010);
    rdy = 1'b1;
    step();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_ovf", ovf_flag, 0);
    repeat (3) step();

    // Reset in the middle of a backpressured transfer
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) pulse(i, i, i, `RSP_STATUS_OK, 0);
    step();
    idle_inputs();
    step();
    chk("mid_rst_pre", bus.rsp_vld, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_now", bus.rsp_vld, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("mid_rst_stale", bus.rsp_vld, 0);
    end

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        s_vld[i] = ($urandom_range(0, 2) == 0);
        s_sid[i] = SW'($urandom);
        s_pkt[i] = PW'($urandom);
        s_st[i]  = 1'($urandom);
        s_err[i] = EW'($urandom);
      end
      rdy      = ($urandom_range(0, 3) != 0);
      stat_clr = ($urandom_range(0, 60) == 0);
      step();
    end
    idle_inputs();
    rdy = 1'b1;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
